// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of the Uart transmitter: buffers core byte writes and
// drains them one at a time with a single-cycle start strobe whenever Uart is idle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PTR_W        = $clog2(DEPTH),
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           clr_overflow,
  input  logic           uart_busy,
  output logic [7:0]     uart_data,
  output logic           uart_write_enable,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count,
  output logic           overflow
);

  localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       data_q;
  logic             ovf_q;
  logic             push, drop, pop;

  always_comb begin
    full      = (count_q == (PTR_W + 1)'(DEPTH));
    empty     = (count_q == '0);
    count     = count_q;
    overflow  = ovf_q;
    uart_data = data_q;
    // Acceptance uses the registered full; a same-cycle pop does not free a slot.
    push      = wr_en && !full;
    drop      = wr_en && full;
  end

  always_comb begin
    state_d           = state_q;
    tmo_d             = tmo_q;
    pop               = 1'b0;
    uart_write_enable = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !uart_busy) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        uart_write_enable = 1'b1;
        tmo_d             = '0;
        state_d           = StWaitBusy;
      end
      StWaitBusy: begin
        if (uart_busy) begin
          state_d = StWaitDone;
        end else begin
          // Uart never acknowledged: give up and treat the byte as sent.
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(BUSY_TIMEOUT)) begin
            state_d = StIdle;
          end
        end
      end
      StWaitDone: begin
        if (!uart_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        data_q   <= mem[rd_ptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_overflow) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer between the core's UART data-register write path and the `Uart` transmitter. Core byte writes to the UART data address are pushed into a FIFO instead of driving the transmitter directly. A drain state machine pops one byte at a time and issues a one-cycle `write_enable` to `Uart` whenever it is idle. Software can therefore burst up to `DEPTH` bytes without polling `busy` per byte, and checks `full` / `overflow` via the line-status register instead.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `PTR_W`, $clog2(DEPTH): pointer width.
- `BUSY_TIMEOUT`, 4: max cycles to wait for `uart_busy` to rise after a strobe.

Ports:
- `clk`  in  1: single clock; every register is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: push strobe; already qualified by the UART data-address decode and the core's `write_enable`.
- `wr_data`  in  8: byte to push (core `write_data[7:0]`).
- `clr_overflow`  in  1: clears the sticky `overflow` flag.
- `uart_busy`  in  1: `busy` from `Uart`.
- `uart_data`  out  8: byte presented to `Uart` `data`; registered.
- `uart_write_enable`  out  1: one-cycle start pulse to `Uart`.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `count`  out  PTR_W+1: current occupancy.
- `overflow`  out  1: sticky; set when a push is dropped.

## Operation

Storage and flags:
- Circular buffer `mem[DEPTH]` of 8-bit entries, with `wr_ptr` and `rd_ptr` each PTR_W bits. Pointers wrap modulo DEPTH naturally.
- `count` is a registered counter; `full` and `empty` are decoded from it.

Push:
- When `wr_en && !full`: write `mem[wr_ptr] <= wr_data` and increment `wr_ptr`.
- When `wr_en && full`: drop the byte, leave pointers unchanged, set `overflow <= 1`.
- Acceptance is judged on the registered `full`. A same-cycle pop does not make room for a push.

Pop:
- Occurs only on the IDLE→ISSUE transition, and only when `!empty`.

Count update:
- Push only: +1.
- Pop only: −1.
- Push and pop in the same cycle: unchanged.

Overflow flag:
- `clr_overflow` clears it.
- If `clr_overflow` and a dropped push occur in the same cycle, set wins.

Drain FSM (states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE):
- **IDLE:** if `!empty && !uart_busy`, load `uart_data <= mem[rd_ptr]`, increment `rd_ptr`, go to ISSUE. Otherwise stay.
- **ISSUE:** `uart_write_enable = 1` (Moore output, asserted in this state only). Clear the timeout counter and go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `uart_busy`, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches `BUSY_TIMEOUT`, go to IDLE; the byte is treated as sent and is not re-sent.
- **WAIT_DONE:** stay while `uart_busy`. When `uart_busy == 0`, go to IDLE.

`uart_data` holds its value from ISSUE until the next IDLE→ISSUE load, so it is stable for the whole transmission.

## Timing

Reset values:
- `uart_data = 0`, `uart_write_enable = 0`.
- `full = 0`, `empty = 1`, `count = 0`, `overflow = 0`.
- Pointers = 0, state = IDLE, timeout counter = 0.

Reset mid-transmission discards all buffered bytes and returns the FSM to IDLE. A frame already started inside `Uart` is not affected.

Latency:
- Push at edge t into an empty FIFO while `uart_busy = 0`: `count = 1` after t.
- The IDLE→ISSUE load happens at edge t+1.
- `uart_write_enable = 1` and valid `uart_data` during cycle t+1..t+2.

Throughput:
- At most one byte per UART frame.
- Minimum gap between strobes is 3 cycles plus the `busy` duration.

Handshake rules:
- `uart_write_enable` is never high for two consecutive cycles.
- `uart_write_enable` is never asserted while `uart_busy` was high in the preceding IDLE cycle.

Wrap-around:
- Pointers roll from DEPTH−1 to 0 with no bubble.
- `full` and `empty` stay correct across wraps because they are count-based.

## Test plan

1. **Single byte:** reset, then push 0x41 with `uart_busy` low, then model `busy` high for 20 cycles starting the cycle after the strobe.
   - Strobe appears 2 cycles after the push, with `uart_data = 0x41`.
   - `count` goes 1→0.
   - No second strobe is issued until `busy` falls.
2. **Burst and order:** push 0x00..0x0F on consecutive cycles with the UART model busy for 10 cycles per byte.
   - `full = 1` is never reached.
   - 16 strobes occur in order 0x00..0x0F.
   - `empty = 1` at the end.
3. **Overflow:** hold `uart_busy = 1` and push 18 bytes.
   - `count` saturates at 16 and `full = 1`.
   - `overflow = 1` after the 17th push.
   - Bytes 17–18 are never transmitted.
   - `clr_overflow` clears the flag.
   - Same-cycle clear and a dropped push leaves `overflow = 1`.
4. **Simultaneous push and pop:** set `count = 3`, then push on the exact IDLE→ISSUE cycle.
   - `count` stays 3.
   - Data order is preserved.
5. **Busy timeout:** the UART model never raises `busy`.
   - FSM returns to IDLE exactly `BUSY_TIMEOUT` cycles after WAIT_BUSY entry.
   - The next byte is strobed; the timed-out byte is not repeated.
6. **Wrap and reset:** cycle 40 bytes through `DEPTH = 16`, then assert `rst` while in WAIT_DONE with 5 bytes queued.
   - All flags, `count`, and outputs return to their reset values the next cycle.
   - No strobe occurs afterwards.
